// File: rtl/key_press_emu_if.sv
// Command/key bundle between a press requester and the key-press emulator.
// master issues commands and observes the key lines; slave is the emulator.
interface key_press_emu_if #(
    parameter int KEY_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_key;
    logic [KEY_W-1:0] key;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_key,
        input  cmd_ready, key, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_key,
        output cmd_ready, key, busy, done
    );
endinterface

// File: rtl/key_press_emu.sv
// Key-press emulator: plays pre-delay, bounce, hold, bounce, gap on one key line.
// Optional KEY_EMU_AUTO_EN adds auto_en for self-issued presses on keys 0,1,2,3,...
module key_press_emu #(
    parameter int KEY_W      = 4,
    parameter int CNT_W      = 22,
    parameter int PRE_CYC    = 50000,
    parameter int BOUNCE_CYC = 500000,
    parameter int HOLD_CYC   = 1500000,
    parameter int GAP_CYC    = 450000
) (
    input  logic sys_clk,
    input  logic sys_rst,
`ifdef KEY_EMU_AUTO_EN
    input  logic auto_en,
`endif
    key_press_emu_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, PRE, BNC_DN, HOLD, BNC_UP, GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, lim;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [1:0]       sel_q, sel_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             rdy_q, busy_q, done_q;
    logic             start, last, bounce, lo;
    logic [1:0]       start_key;

`ifdef KEY_EMU_AUTO_EN
    logic [1:0] idx_q;

    assign start     = (state_q == IDLE) && (auto_en || bus.cmd_valid);
    assign start_key = auto_en ? idx_q : bus.cmd_key;
    assign bus.cmd_ready = rdy_q & ~auto_en;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx_q <= 2'd0;
        end else if (start && auto_en) begin
            idx_q <= idx_q + 2'd1;
        end
    end
`else
    assign start     = (state_q == IDLE) && bus.cmd_valid;
    assign start_key = bus.cmd_key;
    assign bus.cmd_ready = rdy_q;
`endif

    assign bus.key  = key_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_comb begin
        lim = '0;
        unique case (state_q)
            IDLE:           lim = '0;
            PRE:            lim = CNT_W'(PRE_CYC - 1);
            BNC_DN, BNC_UP: lim = CNT_W'(BOUNCE_CYC - 1);
            HOLD:           lim = CNT_W'(HOLD_CYC - 1);
            GAP:            lim = CNT_W'(GAP_CYC - 1);
            default:        lim = '0;
        endcase
    end

    assign last   = (cnt_q == lim);
    assign bounce = (state_q == BNC_DN) || (state_q == BNC_UP);

    // Galois step for x^16+x^14+x^13+x^11, only while bouncing
    assign lfsr_d = bounce
        ? ({1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400))
        : lfsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = PRE;
                cnt_d   = '0;
                sel_d   = start_key;
            end
        end else if (last) begin
            cnt_d = '0;
            unique case (state_q)
                PRE:     state_d = BNC_DN;
                BNC_DN:  state_d = HOLD;
                HOLD:    state_d = BNC_UP;
                BNC_UP:  state_d = GAP;
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Selected line low in HOLD, follows the LFSR while bouncing
    always_comb begin
        lo = (state_d == HOLD) ||
             (((state_d == BNC_DN) || (state_d == BNC_UP)) && !lfsr_d[0]);
        key_d = '1;
        if (lo) key_d[sel_d] = 1'b0;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= 16'hACE1;
            sel_q   <= 2'd0;
            key_q   <= '1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            sel_q   <= sel_d;
            key_q   <= key_d;
            rdy_q   <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == GAP) && (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_key_press_emu.sv
// Scoreboard bench for key_press_emu with short phase lengths.
// Optional auto-mode test compiled under KEY_EMU_AUTO_EN.
module tb_key_press_emu;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef KEY_EMU_AUTO_EN
    logic auto_en = 1'b0;
`endif

    key_press_emu_if #(.KEY_W(4)) bus();

    key_press_emu #(
        .KEY_W(4), .CNT_W(22),
        .PRE_CYC(2), .BOUNCE_CYC(4), .HOLD_CYC(6), .GAP_CYC(3)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
`ifdef KEY_EMU_AUTO_EN
        .auto_en(auto_en),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] key;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    function automatic logic [15:0] adv(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Expected 19 busy cycles then the done cycle
    task automatic push_seq(input logic [1:0] k, input logic rb, input logic rd);
        for (int i = 0; i < 19; i++) begin
            logic b;
            exp_t e;
            if (i < 2) b = 1'b1;
            else if (i < 6) begin b = lfsr_m[0]; lfsr_m = adv(lfsr_m); end
            else if (i < 12) b = 1'b0;
            else if (i < 16) begin b = lfsr_m[0]; lfsr_m = adv(lfsr_m); end
            else b = 1'b1;
            e.key = 4'hF;
            if (!b) e.key[k] = 1'b0;
            e.busy = 1'b1;
            e.done = 1'b0;
            e.rdy  = rb;
            q.push_back(e);
        end
        q.push_back('{key: 4'hF, busy: 1'b0, done: 1'b1, rdy: rd});
    endtask

    always @(negedge clk) begin
        exp_t a, e;
        if (!rst && (bus.busy || bus.done)) begin
            a = '{key: bus.key, busy: bus.busy, done: bus.done, rdy: bus.cmd_ready};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output t=%0t got key=%b busy=%b done=%b rdy=%b",
                         $time, a.key, a.busy, a.done, a.rdy);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL seq_cycle t=%0t got key=%b busy=%b done=%b rdy=%b want key=%b busy=%b done=%b rdy=%b",
                             $time, a.key, a.busy, a.done, a.rdy,
                             e.key, e.busy, e.done, e.rdy);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got=%0d want=0 pending", nm, q.size());
            q.delete();
        end
        cyc(1);
    endtask

    task automatic press(input logic [1:0] k);
        bus.cmd_key   = k;
        bus.cmd_valid = 1'b1;
        push_seq(k, 1'b0, 1'b1);
        cyc(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic reset_now(input string nm);
        #2 rst = 1'b1;
        q.delete();
        lfsr_m = 16'hACE1;
        #1;
        check({nm, "_key"},  bus.key, 4'hF);
        check({nm, "_rdy"},  {3'b0, bus.cmd_ready}, 4'd1);
        check({nm, "_busy"}, {3'b0, bus.busy}, 4'd0);
        check({nm, "_done"}, {3'b0, bus.done}, 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_key   = 2'd0;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // async reset while key 1 is held low
        press(2'd1);
        cyc(7);
        reset_now("rst_hold");
        cyc(1);
        rst = 1'b0;
        cyc(2);

        press(2'd2);
        drain("single");

        // back-to-back: valid held, key changes after first accept
        bus.cmd_key   = 2'd0;
        bus.cmd_valid = 1'b1;
        push_seq(2'd0, 1'b0, 1'b1);
        push_seq(2'd1, 1'b0, 1'b1);
        cyc(1);
        bus.cmd_key = 2'd1;
        cyc(20);
        bus.cmd_valid = 1'b0;
        drain("b2b");

        // command during HOLD must be dropped
        press(2'd1);
        cyc(6);
        bus.cmd_key   = 2'd3;
        bus.cmd_valid = 1'b1;
        cyc(1);
        bus.cmd_valid = 1'b0;
        drain("ignored");
        cyc(25);
        check("ignored_idle", {3'b0, bus.busy}, 4'd0);

        // reset during release bounce, then a clean press from seed
        press(2'd0);
        cyc(12);
        reset_now("rst_bncup");
        cyc(1);
        rst = 1'b0;
        cyc(3);
        press(2'd3);
        drain("after_rst");

`ifdef KEY_EMU_AUTO_EN
        auto_en       = 1'b1;
        bus.cmd_key   = 2'd3;
        bus.cmd_valid = 1'b1;
        #1 check("auto_rdy", {3'b0, bus.cmd_ready}, 4'd0);
        push_seq(2'd0, 1'b0, 1'b0);
        push_seq(2'd1, 1'b0, 1'b0);
        push_seq(2'd2, 1'b0, 1'b0);
        push_seq(2'd3, 1'b0, 1'b1);
        cyc(62);
        auto_en       = 1'b0;
        bus.cmd_valid = 1'b0;
        drain("auto");
        cyc(10);
        check("auto_idle", {3'b0, bus.busy}, 4'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
